interval_timer: RTL and testbench
=================================

INTERVAL_TIMER -- requirements
Module: interval_timer

Interface
REQ-001 SHALL have parameter RELOAD_RST, default 16'hFFFF, reset value of the reload register.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port ce  in  1  register-access chip enable from the CPU bus.
REQ-005 SHALL have port wren  in  1  write strobe, qualified by ce.
REQ-006 SHALL have port addr  in  2  register select: 0 RELOAD_LO, 1 RELOAD_HI, 2 CONTROL, 3 STATUS.
REQ-007 SHALL have port from_cpu  in  8  write data.
REQ-008 SHALL have port to_cpu  out  8  registered read data.
REQ-009 SHALL have port tick_out  out  1  one-cycle expiry pulse, wired to an interrupt-controller input line.

Function
REQ-010 SHALL hold a 16-bit reload register, a 16-bit down counter, an 8-bit prescaler and an 8-bit snapshot register.
REQ-011 SHALL decode CONTROL as: bit0 EN, bit1 AUTO (auto-reload), bit2 PRE (divide-by-256); bits 7:3 SHALL read 0.
REQ-012 SHALL decode STATUS as: bit0 EXPIRED (sticky); bits 7:1 SHALL read 0.
REQ-013 SHALL write reload[7:0] or reload[15:8] on ce&wren with addr 0 or 1; the counter SHALL be unaffected until its next load.
REQ-014 SHALL, on a CONTROL write that changes EN from 0 to 1, load counter from reload and clear the prescaler in that same edge.
REQ-015 SHALL clear EXPIRED on ce&wren to STATUS with from_cpu[0]=1; writing 0 SHALL have no effect.
REQ-016 SHALL update to_cpu on every cycle with ce high, writes included, with one-cycle latency: addr 0 -> counter[7:0], addr 1 -> snapshot, addr 2 -> CONTROL, addr 3 -> STATUS.
REQ-017 SHALL copy counter[15:8] into snapshot on a read of addr 0 (ce&~wren), giving coherent 16-bit reads.
REQ-018 SHALL generate step each cycle when EN=1 and PRE=0; when PRE=1, step only when the prescaler equals 255; the prescaler SHALL count modulo 256 while EN=1.
REQ-019 SHALL, on step with counter!=0, decrement the counter by 1.
REQ-020 SHALL, on step with counter==0: pulse tick_out high for exactly the next cycle, set EXPIRED, then reload the counter if AUTO=1, else clear EN and hold the counter at 0.
REQ-021 SHALL give an auto-reload period of (reload+1) steps; reload=0 SHALL produce a pulse every step.
REQ-022 SHALL, when an expiry and a STATUS clear occur in the same cycle, leave EXPIRED set.
REQ-023 SHALL, when a CONTROL write and a one-shot expiry occur in the same cycle, take the written EN value, while still pulsing tick_out and setting EXPIRED.
REQ-024 SHALL freeze the counter and prescaler while EN=0, and SHALL NOT pulse tick_out.

Reset
REQ-025 SHALL, while rst is low, asynchronously force: reload=RELOAD_RST, counter=0, prescaler=0, snapshot=0, CONTROL=0, EXPIRED=0, to_cpu=0, tick_out=0.
REQ-026 SHALL, on reset mid-count, abandon the count and resume counting only after a new EN 0->1 write.

Structure
REQ-027 SHALL place the register address constants and the CONTROL/STATUS bit indices in shared package timer_pkg.
REQ-028 SHALL implement the prescaler and step generation in sub-module timer_prescaler (inputs clk, rst, en, pre; output step).

Verification
REQ-029 SHALL verify: reload=3, CONTROL=8'h03 -> tick_out pulses every 4 cycles, EXPIRED=1, counter sequence 3,2,1,0,3.
REQ-030 SHALL verify: reload=2, CONTROL=8'h01 -> single pulse after 3 cycles, then CONTROL reads 8'h00 and the counter holds 0.
REQ-031 SHALL verify: reload=1, CONTROL=8'h07 -> pulses are 512 cycles apart.
REQ-032 SHALL verify: counter=16'h1234 frozen (EN=0), read addr 0 then addr 1 -> to_cpu returns 8'h34 then 8'h12.
REQ-033 SHALL verify: STATUS write 8'h01 on the expiry cycle -> EXPIRED reads 1; a later write of 8'h01 -> reads 0.
REQ-034 SHALL verify: rst driven low asynchronously mid-count -> all outputs 0 immediately, reload reads back RELOAD_RST.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared register map and CONTROL/STATUS field positions for the interval timer.
package timer_pkg;

  typedef enum logic [1:0] {
    ADDR_RELOAD_LO = 2'd0,
    ADDR_RELOAD_HI = 2'd1,
    ADDR_CONTROL   = 2'd2,
    ADDR_STATUS    = 2'd3
  } reg_addr_e;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_AUTO    = 1;
  localparam int CTRL_PRE     = 2;
  localparam int STAT_EXPIRED = 0;

  typedef struct packed {
    logic pre;
    logic arl;
    logic en;
  } ctrl_t;

  function automatic logic [7:0] ctrl_byte(input ctrl_t c);
    logic [7:0] b;
    b = '0;
    b[CTRL_EN]   = c.en;
    b[CTRL_AUTO] = c.arl;
    b[CTRL_PRE]  = c.pre;
    return b;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Divide-by-256 prescaler and counter step strobe for the interval timer.
module timer_prescaler (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic pre,
  output logic step
);

  logic [7:0] psc_q, psc_d, psc_eff;
  logic       en_q;

  // The first enabled cycle is the one right after the EN 0->1 load, so the
  // count restarts from 0 there; otherwise the value is frozen while disabled.
  assign psc_eff = en_q ? psc_q : 8'd0;
  assign psc_d   = en ? psc_eff + 8'd1 : psc_q;
  assign step    = en & (~pre | (psc_eff == 8'hFF));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      psc_q <= '0;
      en_q  <= 1'b0;
    end else begin
      psc_q <= psc_d;
      en_q  <= en;
    end
  end

endmodule

// File: rtl/interval_timer.sv
// CPU-programmable 16-bit down-counting interval timer with one-shot/auto-reload and expiry pulse.
module interval_timer
  import timer_pkg::*;
#(
  parameter logic [15:0] RELOAD_RST = 16'hFFFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       wren,
  input  logic [1:0] addr,
  input  logic [7:0] from_cpu,
  output logic [7:0] to_cpu,
  output logic       tick_out
);

  logic [15:0] reload_q, reload_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  snap_q, snap_d;
  logic [7:0]  rdata_q, rdata_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic        expired_q, expired_d;
  logic        tick_q, tick_d;

  reg_addr_e sel;
  logic      acc_wr, acc_rd, ctrl_wr, stat_wr, load, step, expire;

  assign sel     = reg_addr_e'(addr);
  assign acc_wr  = ce & wren;
  assign acc_rd  = ce & ~wren;
  assign ctrl_wr = acc_wr & (sel == ADDR_CONTROL);
  assign stat_wr = acc_wr & (sel == ADDR_STATUS);
  assign load    = ctrl_wr & ~ctrl_q.en & from_cpu[CTRL_EN];
  assign expire  = step & (cnt_q == 16'd0);

  timer_prescaler u_psc (
    .clk  (clk),
    .rst  (rst),
    .en   (ctrl_q.en),
    .pre  (ctrl_q.pre),
    .step (step)
  );

  always_comb begin
    reload_d  = reload_q;
    cnt_d     = cnt_q;
    snap_d    = snap_q;
    rdata_d   = rdata_q;
    ctrl_d    = ctrl_q;
    expired_d = expired_q;
    tick_d    = expire;

    if (acc_wr && sel == ADDR_RELOAD_LO) reload_d[7:0]  = from_cpu;
    if (acc_wr && sel == ADDR_RELOAD_HI) reload_d[15:8] = from_cpu;

    // A CPU write to CONTROL overrides the one-shot auto-disable in the same cycle.
    if (expire && !ctrl_q.arl) ctrl_d.en = 1'b0;
    if (ctrl_wr) begin
      ctrl_d.en  = from_cpu[CTRL_EN];
      ctrl_d.arl = from_cpu[CTRL_AUTO];
      ctrl_d.pre = from_cpu[CTRL_PRE];
    end

    if (load) begin
      cnt_d = reload_q;
    end else if (step) begin
      if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
      else                cnt_d = ctrl_q.arl ? reload_q : 16'd0;
    end

    if (stat_wr && from_cpu[STAT_EXPIRED]) expired_d = 1'b0;
    if (expire)                            expired_d = 1'b1;

    if (acc_rd && sel == ADDR_RELOAD_LO) snap_d = cnt_q[15:8];

    if (ce) begin
      case (sel)
        ADDR_RELOAD_LO: rdata_d = cnt_q[7:0];
        ADDR_RELOAD_HI: rdata_d = snap_q;
        ADDR_CONTROL:   rdata_d = ctrl_byte(ctrl_q);
        ADDR_STATUS:    rdata_d = {7'd0, expired_q};
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reload_q  <= RELOAD_RST;
      cnt_q     <= '0;
      snap_q    <= '0;
      rdata_q   <= '0;
      ctrl_q    <= '0;
      expired_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      reload_q  <= reload_d;
      cnt_q     <= cnt_d;
      snap_q    <= snap_d;
      rdata_q   <= rdata_d;
      ctrl_q    <= ctrl_d;
      expired_q <= expired_d;
      tick_q    <= tick_d;
    end
  end

  assign to_cpu   = rdata_q;
  assign tick_out = tick_q;

endmodule

// File: tb/tb_interval_timer.sv
// Directed bench for interval_timer: bus access, count sequences, prescaler, sticky status, reset.
module tb_interval_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ce = 1'b0;
  logic       wren = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [7:0] from_cpu = 8'd0;
  logic [7:0] to_cpu;
  logic       tick_out;

  int n_cmp = 0;
  int n_err = 0;

  interval_timer #(.RELOAD_RST(16'hFFFF)) dut (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .wren     (wren),
    .addr     (addr),
    .from_cpu (from_cpu),
    .to_cpu   (to_cpu),
    .tick_out (tick_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus tasks start and end at a falling edge; the access lands on the rising edge between.
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    ce = 1'b1; wren = 1'b1; addr = a; from_cpu = d;
    @(negedge clk);
    ce = 1'b0; wren = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    ce = 1'b1; wren = 1'b0; addr = a;
    @(negedge clk);
    ce = 1'b0;
    d = to_cpu;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] v;
    logic [7:0] exp_cnt [8];
    int first, second;

    // reset state
    #12;
    chk("rst_to_cpu", to_cpu, 8'h00);
    chk("rst_tick", tick_out, 1'b0);
    @(negedge clk); rst = 1'b1;
    rd(2'd2, v); chk("rst_ctrl", v, 8'h00);
    rd(2'd3, v); chk("rst_status", v, 8'h00);

    // auto-reload, reload=3: counter 3,2,1,0,3,... tick every 4 cycles
    exp_cnt = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd3, 8'd2, 8'd1, 8'd0};
    wr(2'd0, 8'h03); wr(2'd1, 8'h00); wr(2'd2, 8'h03);
    for (int i = 0; i < 8; i++) begin
      rd(2'd0, v);
      chk($sformatf("auto_cnt%0d", i), v, exp_cnt[i]);
      chk($sformatf("auto_tick%0d", i), tick_out, (i == 3 || i == 7) ? 1'b1 : 1'b0);
    end
    rd(2'd3, v); chk("auto_expired", v, 8'h01);
    wr(2'd2, 8'h00);
    wr(2'd3, 8'h01);
    rd(2'd3, v); chk("status_cleared", v, 8'h00);

    // one-shot, reload=2: counter 2,1,0 then holds 0, single tick, EN dropped
    wr(2'd0, 8'h02); wr(2'd1, 8'h00); wr(2'd2, 8'h01);
    for (int i = 0; i < 5; i++) begin
      rd(2'd0, v);
      chk($sformatf("one_cnt%0d", i), v, (i < 3) ? 8'(2 - i) : 8'd0);
      chk($sformatf("one_tick%0d", i), tick_out, (i == 2) ? 1'b1 : 1'b0);
    end
    rd(2'd2, v); chk("one_ctrl", v, 8'h00);
    rd(2'd0, v); chk("one_hold", v, 8'h00);

    // frozen 0x1234: coherent two-byte read, reload write does not touch counter
    wr(2'd0, 8'h34); wr(2'd1, 8'h12); wr(2'd2, 8'h05); wr(2'd2, 8'h00);
    rd(2'd0, v); chk("frz_lo", v, 8'h34);
    rd(2'd1, v); chk("frz_hi", v, 8'h12);
    wr(2'd0, 8'hAA);
    rd(2'd0, v); chk("frz_reload_wr", v, 8'h34);
    rd(2'd2, v); chk("frz_ctrl", v, 8'h00);

    // STATUS clear coincident with expiry keeps EXPIRED set
    wr(2'd3, 8'h01);
    wr(2'd0, 8'h02); wr(2'd1, 8'h00); wr(2'd2, 8'h01);
    idle(2);
    wr(2'd3, 8'h01);
    chk("coin_tick", tick_out, 1'b1);
    rd(2'd3, v); chk("coin_expired", v, 8'h01);
    wr(2'd3, 8'h00);
    rd(2'd3, v); chk("status_wr0", v, 8'h01);
    wr(2'd3, 8'h01);
    rd(2'd3, v); chk("status_wr1", v, 8'h00);

    // CONTROL write coincident with one-shot expiry: written EN wins, tick still fires
    wr(2'd2, 8'h01);
    idle(2);
    wr(2'd2, 8'h01);
    chk("cw_tick", tick_out, 1'b1);
    rd(2'd2, v); chk("cw_ctrl_en", v, 8'h01);
    rd(2'd3, v); chk("cw_expired", v, 8'h01);
    rd(2'd2, v); chk("cw_ctrl_after", v, 8'h00);

    // prescaled auto-reload, reload=1: pulses 512 cycles apart
    wr(2'd0, 8'h01); wr(2'd1, 8'h00); wr(2'd2, 8'h07);
    first = -1; second = -1;
    for (int k = 1; k <= 1100; k++) begin
      @(negedge clk);
      if (tick_out) begin
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
    end
    chk("pre_first", first, 512);
    chk("pre_period", second - first, 512);
    wr(2'd2, 8'h00);

    // asynchronous reset mid-count
    wr(2'd0, 8'h05); wr(2'd1, 8'h00); wr(2'd2, 8'h03);
    rd(2'd2, v); chk("prerst_ctrl", v, 8'h03);
    #3 rst = 1'b0;
    #1;
    chk("arst_to_cpu", to_cpu, 8'h00);
    chk("arst_tick", tick_out, 1'b0);
    @(negedge clk); rst = 1'b1;
    rd(2'd0, v); chk("arst_cnt", v, 8'h00);
    rd(2'd2, v); chk("arst_ctrl", v, 8'h00);
    rd(2'd3, v); chk("arst_status", v, 8'h00);
    idle(3);
    rd(2'd0, v); chk("arst_no_resume", v, 8'h00);
    chk("arst_no_tick", tick_out, 1'b0);
    wr(2'd2, 8'h05);
    rd(2'd0, v); chk("arst_reload_lo", v, 8'hFF);
    rd(2'd1, v); chk("arst_reload_hi", v, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
